// File: rtl/branch_tag_ctrl_pkg.sv
// rtl/branch_tag_ctrl_pkg.sv - shared issue-stage types for branch tag allocation
package branch_tag_ctrl_pkg;

  localparam int NUM_TAGS = 8;
  localparam int BID_W    = $clog2(NUM_TAGS);

  typedef logic [BID_W-1:0]    bid_t;
  typedef logic [BID_W:0]      cnt_t;
  typedef logic [NUM_TAGS-1:0] tag_mask_t;

  // Sets len consecutive bits starting at start, wrapping around the ring.
  function automatic tag_mask_t range_mask(input bid_t start, input cnt_t len);
    tag_mask_t m;
    bid_t      idx;
    m = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      idx = start + bid_t'(i);
      if (cnt_t'(i) < len) m[idx] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/branch_tag_ctrl.sv
// rtl/branch_tag_ctrl.sv - circular branch tag ring with dual-slot allocation and mispredict flush
module branch_tag_ctrl
  import branch_tag_ctrl_pkg::*;
#(
  parameter int NUM_TAGS = branch_tag_ctrl_pkg::NUM_TAGS,
  parameter int BID_W    = branch_tag_ctrl_pkg::BID_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_1_vld,
  input  logic                req_1_br,
  input  logic                req_2_vld,
  input  logic                req_2_br,
  output logic                alloc_ready,
  output logic [BID_W-1:0]    alloc_1_bid,
  output logic [BID_W-1:0]    alloc_2_bid,
  input  logic                resolve_vld,
  input  logic [BID_W-1:0]    resolve_bid,
  input  logic                resolve_mispredict,
  output logic                flush_en,
  output logic [BID_W-1:0]    flush_id,
  output logic [NUM_TAGS-1:0] flush_mask,
  output logic                branch_full,
  output logic [BID_W:0]      busy_count
);

  logic [BID_W-1:0]    head_q, head_d;
  logic [BID_W-1:0]    tail_q, tail_d;
  logic [BID_W:0]      count_q, count_d;
  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic                flush_en_q, flush_en_d;
  logic [BID_W-1:0]    flush_id_q, flush_id_d;
  logic [NUM_TAGS-1:0] flush_mask_q, flush_mask_d;

  logic                slot_1_br, slot_2_br;
  logic [1:0]          need;
  logic [BID_W:0]      free_tags;
  logic                accept;
  logic [BID_W-1:0]    resolve_off;
  logic                resolve_hit;
  logic                mispredict_hit;
  logic [NUM_TAGS-1:0] kill_mask;
  logic [BID_W-1:0]    head_p1;
  logic                retire_0, retire_1;
  logic [1:0]          retire_n;

  assign slot_1_br = req_1_vld & req_1_br;
  assign slot_2_br = req_2_vld & req_2_br;
  assign need      = {1'b0, slot_1_br} + {1'b0, slot_2_br};
  assign free_tags = (BID_W+1)'(NUM_TAGS) - count_q;

  // Any mispredict on the resolve port blocks allocation, busy or not.
  assign alloc_ready = (free_tags >= (BID_W+1)'(need)) && !(resolve_vld && resolve_mispredict);
  assign accept      = alloc_ready && (need != 2'd0);
  assign alloc_1_bid = tail_q;
  assign alloc_2_bid = slot_1_br ? tail_q + 1'b1 : tail_q;

  // A tag only counts as busy if it lies inside the live head..tail window.
  assign resolve_off    = resolve_bid - head_q;
  assign resolve_hit    = resolve_vld && ({1'b0, resolve_off} < count_q) && busy_q[resolve_bid];
  assign mispredict_hit = resolve_hit && resolve_mispredict;
  assign kill_mask      = range_mask(resolve_bid, count_q - {1'b0, resolve_off});

  assign head_p1  = head_q + 1'b1;
  assign retire_0 = (count_q != '0) && !busy_q[head_q];
  assign retire_1 = retire_0 && (count_q >= (BID_W+1)'(2)) && !busy_q[head_p1];
  assign retire_n = {1'b0, retire_0} + {1'b0, retire_1};

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    busy_d       = busy_q;
    flush_en_d   = 1'b0;
    flush_id_d   = '0;
    flush_mask_d = '0;
    if (mispredict_hit) begin
      busy_d       = busy_q & ~kill_mask;
      tail_d       = resolve_bid;
      count_d      = {1'b0, resolve_off};
      flush_en_d   = 1'b1;
      flush_id_d   = resolve_bid;
      flush_mask_d = kill_mask;
    end else begin
      if (resolve_hit) busy_d[resolve_bid] = 1'b0;
      if (accept) begin
        if (slot_1_br) busy_d[alloc_1_bid] = 1'b1;
        if (slot_2_br) busy_d[alloc_2_bid] = 1'b1;
        tail_d = tail_q + BID_W'(need);
      end
      head_d  = head_q + BID_W'(retire_n);
      count_d = count_q + (accept ? (BID_W+1)'(need) : '0) - (BID_W+1)'(retire_n);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      busy_q       <= '0;
      flush_en_q   <= 1'b0;
      flush_id_q   <= '0;
      flush_mask_q <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      flush_en_q   <= flush_en_d;
      flush_id_q   <= flush_id_d;
      flush_mask_q <= flush_mask_d;
    end
  end

  assign flush_en    = flush_en_q;
  assign flush_id    = flush_id_q;
  assign flush_mask  = flush_mask_q;
  assign busy_count  = count_q;
  assign branch_full = free_tags < (BID_W+1)'(2);

endmodule

// File: tb/tb_branch_tag_ctrl.sv
// tb/tb_branch_tag_ctrl.sv - directed vector bench for branch_tag_ctrl
module tb_branch_tag_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_1_vld, req_1_br, req_2_vld, req_2_br;
  logic       alloc_ready;
  logic [2:0] alloc_1_bid, alloc_2_bid;
  logic       resolve_vld, resolve_mispredict;
  logic [2:0] resolve_bid;
  logic       flush_en;
  logic [2:0] flush_id;
  logic [7:0] flush_mask;
  logic       branch_full;
  logic [3:0] busy_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_tag_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .req_1_vld          (req_1_vld),
    .req_1_br           (req_1_br),
    .req_2_vld          (req_2_vld),
    .req_2_br           (req_2_br),
    .alloc_ready        (alloc_ready),
    .alloc_1_bid        (alloc_1_bid),
    .alloc_2_bid        (alloc_2_bid),
    .resolve_vld        (resolve_vld),
    .resolve_bid        (resolve_bid),
    .resolve_mispredict (resolve_mispredict),
    .flush_en           (flush_en),
    .flush_id           (flush_id),
    .flush_mask         (flush_mask),
    .branch_full        (branch_full),
    .busy_count         (busy_count)
  );

  typedef struct {
    logic [3:0] req;   // {v1, b1, v2, b2}
    logic [1:0] res;   // {resolve_vld, mispredict}
    logic [2:0] rbid;
    logic       rdy;
    logic [2:0] bid1;
    logic [2:0] bid2;
    logic       fe;
    logic [2:0] fid;
    logic [7:0] fmask;
    logic       full;
    logic [3:0] cnt;
    logic [2:0] head;
    logic [2:0] tail;
  } vec_t;

  localparam int NV = 32;
  localparam logic [3:0] BB = 4'b1111, B1 = 4'b1100, B2 = 4'b0011, NB = 4'b1010, NO = 4'b0000;
  localparam logic [1:0] RN = 2'b00, RC = 2'b10, RM = 2'b11;

  vec_t v [NV];

  task automatic chk(input string name, input int row, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0d required=%0d", name, row, act, exp);
    end
  endtask

  task automatic drive_idle();
    {req_1_vld, req_1_br, req_2_vld, req_2_br} = 4'b0000;
    {resolve_vld, resolve_mispredict} = 2'b00;
    resolve_bid = 3'd0;
  endtask

  initial begin
    //        req res rbid  rdy  bid1  bid2  fe   fid   fmask  full cnt   head  tail
    v[0]  = '{BB, RN, 3'd0, 1'b1, 3'd0, 3'd1, 1'b0, 3'd0, 8'h00, 1'b0, 4'd0, 3'd0, 3'd0};
    v[1]  = '{BB, RN, 3'd0, 1'b1, 3'd2, 3'd3, 1'b0, 3'd0, 8'h00, 1'b0, 4'd2, 3'd0, 3'd2};
    v[2]  = '{BB, RN, 3'd0, 1'b1, 3'd4, 3'd5, 1'b0, 3'd0, 8'h00, 1'b0, 4'd4, 3'd0, 3'd4};
    v[3]  = '{BB, RN, 3'd0, 1'b1, 3'd6, 3'd7, 1'b0, 3'd0, 8'h00, 1'b0, 4'd6, 3'd0, 3'd6};
    v[4]  = '{BB, RN, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1, 4'd8, 3'd0, 3'd0};
    v[5]  = '{B1, RN, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1, 4'd8, 3'd0, 3'd0};
    v[6]  = '{NB, RN, 3'd0, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1, 4'd8, 3'd0, 3'd0};
    v[7]  = '{NO, RM, 3'd6, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1, 4'd8, 3'd0, 3'd0};
    v[8]  = '{NO, RN, 3'd0, 1'b1, 3'd0, 3'd0, 1'b1, 3'd6, 8'hC0, 1'b0, 4'd6, 3'd0, 3'd6};
    v[9]  = '{NO, RM, 3'd2, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 4'd6, 3'd0, 3'd6};
    v[10] = '{NO, RN, 3'd0, 1'b1, 3'd0, 3'd0, 1'b1, 3'd2, 8'h3C, 1'b0, 4'd2, 3'd0, 3'd2};
    v[11] = '{NO, RN, 3'd0, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 4'd2, 3'd0, 3'd2};
    v[12] = '{NO, RC, 3'd0, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 4'd2, 3'd0, 3'd2};
    v[13] = '{NO, RC, 3'd1, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 4'd2, 3'd0, 3'd2};
    v[14] = '{NO, RN, 3'd0, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 4'd1, 3'd1, 3'd2};
    v[15] = '{BB, RN, 3'd0, 1'b1, 3'd2, 3'd3, 1'b0, 3'd0, 8'h00, 1'b0, 4'd0, 3'd2, 3'd2};
    v[16] = '{NO, RC, 3'd3, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 4'd2, 3'd2, 3'd4};
    v[17] = '{NO, RN, 3'd0, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 4'd2, 3'd2, 3'd4};
    v[18] = '{NO, RN, 3'd0, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 4'd2, 3'd2, 3'd4};
    v[19] = '{BB, RN, 3'd0, 1'b1, 3'd4, 3'd5, 1'b0, 3'd0, 8'h00, 1'b0, 4'd2, 3'd2, 3'd4};
    v[20] = '{BB, RM, 3'd5, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 4'd4, 3'd2, 3'd6};
    v[21] = '{B1, RN, 3'd0, 1'b1, 3'd5, 3'd0, 1'b1, 3'd5, 8'h20, 1'b0, 4'd3, 3'd2, 3'd5};
    v[22] = '{NO, RC, 3'd2, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 4'd4, 3'd2, 3'd6};
    v[23] = '{NO, RC, 3'd4, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 4'd4, 3'd2, 3'd6};
    v[24] = '{NO, RC, 3'd5, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 4'd2, 3'd4, 3'd6};
    v[25] = '{NO, RN, 3'd0, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 4'd1, 3'd5, 3'd6};
    v[26] = '{BB, RN, 3'd0, 1'b1, 3'd6, 3'd7, 1'b0, 3'd0, 8'h00, 1'b0, 4'd0, 3'd6, 3'd6};
    v[27] = '{BB, RN, 3'd0, 1'b1, 3'd0, 3'd1, 1'b0, 3'd0, 8'h00, 1'b0, 4'd2, 3'd6, 3'd0};
    v[28] = '{NO, RM, 3'd3, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 4'd4, 3'd6, 3'd2};
    v[29] = '{NO, RN, 3'd0, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 4'd4, 3'd6, 3'd2};
    v[30] = '{B2, RN, 3'd0, 1'b1, 3'd0, 3'd2, 1'b0, 3'd0, 8'h00, 1'b0, 4'd4, 3'd6, 3'd2};
    v[31] = '{NO, RN, 3'd0, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 4'd5, 3'd6, 3'd3};

    rst = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_alloc_ready", -1, alloc_ready, 1);
    chk("reset_branch_full", -1, branch_full, 0);
    chk("reset_busy_count", -1, busy_count, 0);
    chk("reset_flush_en", -1, flush_en, 0);
    chk("reset_head", -1, dut.head_q, 0);
    chk("reset_tail", -1, dut.tail_q, 0);

    for (int i = 0; i < NV; i++) begin
      {req_1_vld, req_1_br, req_2_vld, req_2_br} = v[i].req;
      {resolve_vld, resolve_mispredict} = v[i].res;
      resolve_bid = v[i].rbid;
      #1;
      chk("alloc_ready", i, alloc_ready, v[i].rdy);
      if (v[i].rdy && v[i].req[2]) chk("alloc_1_bid", i, alloc_1_bid, v[i].bid1);
      if (v[i].rdy && v[i].req[0]) chk("alloc_2_bid", i, alloc_2_bid, v[i].bid2);
      chk("flush_en", i, flush_en, v[i].fe);
      chk("flush_id", i, flush_id, v[i].fid);
      chk("flush_mask", i, flush_mask, v[i].fmask);
      chk("branch_full", i, branch_full, v[i].full);
      chk("busy_count", i, busy_count, v[i].cnt);
      chk("head", i, dut.head_q, v[i].head);
      chk("tail", i, dut.tail_q, v[i].tail);
      @(negedge clk);
    end

    // Reset coinciding with a mispredict on a busy tag must swallow the flush.
    rst = 1'b0;
    {req_1_vld, req_1_br, req_2_vld, req_2_br} = 4'b1111;
    {resolve_vld, resolve_mispredict} = 2'b11;
    resolve_bid = 3'd7;
    #1;
    chk("rstmp_alloc_ready", 100, alloc_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    #1;
    chk("rstmp_flush_en", 101, flush_en, 0);
    chk("rstmp_flush_id", 101, flush_id, 0);
    chk("rstmp_flush_mask", 101, flush_mask, 0);
    chk("rstmp_busy_count", 101, busy_count, 0);
    chk("rstmp_alloc_ready", 101, alloc_ready, 1);
    chk("rstmp_branch_full", 101, branch_full, 0);
    @(negedge clk);
    {req_1_vld, req_1_br, req_2_vld, req_2_br} = 4'b1111;
    #1;
    chk("rstmp_flush_en_next", 102, flush_en, 0);
    chk("rstmp_alloc_1_bid", 102, alloc_1_bid, 0);
    chk("rstmp_alloc_2_bid", 102, alloc_2_bid, 1);
    @(negedge clk);
    drive_idle();
    #1;
    chk("rstmp_busy_count_after", 103, busy_count, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
